byte_unstriping: RTL and testbench

//  Receive-side stage that consumes the two-lane output of the byte striping block.

---
 rtl/byte_unstriping.sv | 148 ++++++++++++++
 tb/tb_byte_unstriping.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_unstriping.sv
// Two-lane to single-stream byte merger: per-lane FIFOs absorb skew, a
// two-state selector restores lane 0 / lane 1 order. Optional sticky overflow flag: UNSTRIPE_OVF_EN.
module byte_unstriping #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out
`ifdef UNSTRIPE_OVF_EN
    ,
    output logic              overflow
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic {
        SEL_L0 = 1'b0,
        SEL_L1 = 1'b1
    } sel_e;

    logic [1:0]        lane_valid;
    logic [DATA_W-1:0] lane_data [2];
    logic [DATA_W-1:0] head      [2];
    logic [1:0]        empty;
    logic [1:0]        full;
    logic [1:0]        pop;

    assign lane_valid   = {valid_1, valid_0};
    assign lane_data[0] = lane_0;
    assign lane_data[1] = lane_1;

    // One FIFO per lane; the extra pointer bit tells full from empty.
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
        logic              push;

        assign empty[g] = (wr_ptr_q == rd_ptr_q);
        assign full[g]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign push     = lane_valid[g] && !full[g];
        assign head[g]  = mem_q[rd_ptr_q[AW-1:0]];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop[g]) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end

        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        always_ff @(posedge clk_2f) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // NOTE: storage is not reset; the pointers alone decide which entries are live.
        always_ff @(posedge clk_2f) begin
            if (push && !reset) begin
                mem_q[wr_ptr_q[AW-1:0]] <= lane_data[g];
            end
        end
    end

    sel_e              sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;

    // Strict order: wait on the selected lane, never skip to the other one.
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        sel_d       = sel_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        pop         = '0;
        case (sel_q)
            SEL_L0: begin
                if (!empty[0]) begin
                    pop[0]      = 1'b1;
                    data_out_d  = head[0];
                    valid_out_d = 1'b1;
                    sel_d       = SEL_L1;
                end
            end
            SEL_L1: begin
                if (!empty[1]) begin
                    pop[1]      = 1'b1;
                    data_out_d  = head[1];
                    valid_out_d = 1'b1;
                    sel_d       = SEL_L0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel_q       <= SEL_L0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef UNSTRIPE_OVF_EN
    logic overflow_q, overflow_d;

    // A push offered to a full lane is a drop; the flag stays set until reset.
    always_comb begin
        overflow_d = overflow_q | (|(lane_valid & full));
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Scoreboard bench for byte_unstriping: expected stream bytes are queued as
// stimulus is driven and compared in order whenever valid_out is seen.
module tb_byte_unstriping;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk_2f  = 1'b0;
    logic              reset   = 1'b1;
    logic [DATA_W-1:0] lane_0  = '0;
    logic              valid_0 = 1'b0;
    logic [DATA_W-1:0] lane_1  = '0;
    logic              valid_1 = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
`ifdef UNSTRIPE_OVF_EN
    logic              overflow;
`endif

    int                total = 0;
    int                bad   = 0;
    int                n_out = 0;
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] sb_exp;

    always #5 clk_2f = ~clk_2f;

    byte_unstriping #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .data_out (data_out),
        .valid_out(valid_out)
`ifdef UNSTRIPE_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    // Scoreboard: every valid output byte must be the next queued stream byte.
    always @(negedge clk_2f) begin
        if (valid_out === 1'b1) begin
            n_out++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: data_out=%02h while no byte was expected", data_out);
            end else begin
                sb_exp = sb.pop_front();
                if (data_out !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_order: data_out=%02h expected=%02h", data_out, sb_exp);
                end
            end
        end
    end

    task automatic drive(input logic v0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [DATA_W-1:0] d1);
        @(negedge clk_2f);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: %0d bytes never came out, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        // Bytes offered while reset is high must vanish.
        reset = 1'b1;
        drive(1'b1, 8'hE1, 1'b1, 8'hE2);
        @(negedge clk_2f);
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: valid_out=%b want 0", valid_out);
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: data_out=%02h want 00", data_out);
        end
`ifdef UNSTRIPE_OVF_EN
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: overflow=%b want 0", overflow);
        end
`endif
        reset   = 1'b0;
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2f);
            total++;
            if (valid_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_discard: valid_out=%b in idle cycle %0d want 0", valid_out, i);
            end
        end
    endtask

    task automatic test_aligned;
        sb.push_back(8'hAA);
        sb.push_back(8'hBB);
        sb.push_back(8'hCC);
        sb.push_back(8'hDD);
        drive(1'b1, 8'hAA, 1'b1, 8'hBB);
        drive(1'b1, 8'hCC, 1'b1, 8'hDD);
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL aligned_latency: valid_out=%b one cycle after input want 0", valid_out);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'hAA) begin
            bad++;
            $display("FAIL aligned_first: valid_out=%b data_out=%02h want 1/AA", valid_out, data_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2f);
            total++;
            if (valid_out !== 1'b1) begin
                bad++;
                $display("FAIL aligned_burst: valid_out=%b at output %0d want 1", valid_out, i + 2);
            end
        end
        @(negedge clk_2f);
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL aligned_end: valid_out=%b after 4 bytes want 0", valid_out);
        end
        check_drained("aligned");
    endtask

    task automatic test_skew;
        sb.push_back(8'h10);
        sb.push_back(8'h11);
        drive(1'b0, 8'h00, 1'b1, 8'h11);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drive(1'b1, 8'h10, 1'b0, 8'h00);
            else        drive(1'b0, 8'h00, 1'b0, 8'h00);
            total++;
            if (valid_out !== 1'b0) begin
                bad++;
                $display("FAIL skew_hold: valid_out=%b in wait cycle %0d want 0", valid_out, i);
            end
        end
        @(negedge clk_2f);
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'h10) begin
            bad++;
            $display("FAIL skew_l0: valid_out=%b data_out=%02h want 1/10", valid_out, data_out);
        end
        @(negedge clk_2f);
        total++;
        if (valid_out !== 1'b1 || data_out !== 8'h11) begin
            bad++;
            $display("FAIL skew_l1: valid_out=%b data_out=%02h want 1/11", valid_out, data_out);
        end
        idle(2);
        check_drained("skew");
    endtask

    task automatic test_gaps;
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] b0, b1;
            b0 = DATA_W'(2 * i + 1);
            b1 = DATA_W'(2 * i + 2);
            sb.push_back(b0);
            sb.push_back(b1);
            drive(1'b1, b0, 1'b1, b1);
            idle(1);
        end
        idle(4);
        check_drained("gaps");
    endtask

    task automatic test_overflow;
        // One lone lane 0 byte leaves the selector waiting on lane 1.
        sb.push_back(8'h40);
        drive(1'b1, 8'h40, 1'b0, 8'h00);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(DATA_W'(8'h50 + i));
            if (i < 4) sb.push_back(DATA_W'(8'h41 + i));
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DATA_W'(8'h41 + i), 1'b0, 8'h00);
`ifdef UNSTRIPE_OVF_EN
            if (i == 4) begin
                total++;
                if (overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_early: overflow=%b before any drop want 0", overflow);
                end
            end
`endif
        end
        idle(1);
`ifdef UNSTRIPE_OVF_EN
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: overflow=%b after drops want 1", overflow);
        end
`endif
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, DATA_W'(8'h50 + i));
        idle(12);
        check_drained("overflow");
`ifdef UNSTRIPE_OVF_EN
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: overflow=%b after drain want 1", overflow);
        end
`endif
    endtask

    task automatic test_reset_mid;
        sb.push_back(8'h61);
        sb.push_back(8'h62);
        drive(1'b1, 8'h61, 1'b1, 8'h62);
        drive(1'b0, 8'h00, 1'b1, 8'h63);
        drive(1'b0, 8'h00, 1'b1, 8'h64);
        drive(1'b0, 8'h00, 1'b1, 8'h65);
        idle(1);
        check_drained("pre_reset");
        @(negedge clk_2f);
        reset = 1'b1;
        @(negedge clk_2f);
        total++;
        if (valid_out !== 1'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_out: valid_out=%b data_out=%02h want 0/00", valid_out, data_out);
        end
`ifdef UNSTRIPE_OVF_EN
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_ovf: overflow=%b want 0", overflow);
        end
`endif
        reset = 1'b0;
        // Stale lane 1 bytes must be gone: restart pairs 71 with 72 only.
        sb.push_back(8'h71);
        sb.push_back(8'h72);
        drive(1'b0, 8'h00, 1'b1, 8'h72);
        drive(1'b1, 8'h71, 1'b0, 8'h00);
        idle(6);
        check_drained("restart");
    endtask

    task automatic test_equiv;
        int n_start;
        int sent;
        int cycles;
        n_start = n_out;
        sent    = 0;
        cycles  = 0;
        // Striping model: stream byte k goes to lane k%2 on a random valid_in cycle.
        while (sent < 40 && cycles < 1000) begin
            logic [DATA_W-1:0] b;
            cycles++;
            if ($urandom_range(0, 1) == 1) begin
                b = DATA_W'($urandom_range(0, 255));
                sb.push_back(b);
                if (sent % 2 == 0) drive(1'b1, b, 1'b0, 8'h00);
                else               drive(1'b0, 8'h00, 1'b1, b);
                sent++;
            end else begin
                idle(1);
            end
        end
        idle(6);
        check_drained("equiv");
        total++;
        if (n_out - n_start != 40) begin
            bad++;
            $display("FAIL equiv_count: %0d bytes out want 40", n_out - n_start);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skew();
        test_gaps();
        test_overflow();
        test_reset_mid();
        test_equiv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
